tdm_slot_arbiter: RTL and testbench

Time-division slot arbiter that consumes the one-hot phase vector produced by the ring counter. Each of N request channels may hand one data word over only while its own phase bit is active. Granted words go through a single registered valid/ready output stage. The block also checks phase integrity (one-hot and correct rotation) and counts completed ring revolutions.

---
 rtl/tdm_slot_arbiter.sv | 124 ++++++++++++
 tb/tb_tdm_slot_arbiter.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/tdm_slot_arbiter.sv
// -----------------------------------------------------------------------------
// tdm_slot_arbiter
//
// Time-division slot arbiter driven by a one-hot ring-counter phase vector.
// Channel i may hand over one data word only while phase[i] is the single
// active bit. Accepted words pass through one registered valid/ready output
// stage that sustains one word per cycle. The block also watches the phase
// vector for one-hot violations and for broken rotation, and counts
// completed ring revolutions.
//
// Parameters:
//   N  number of channels / ring width (N >= 2)
//   W  data width per channel
//   F  frame counter width
//
// Ports:
//   clk         system clock, rising edge
//   rst         asynchronous active-high reset
//   phase       one-hot slot vector, rotates left each cycle (bit N-1 -> bit 0)
//   in_valid    per-channel request valid
//   in_data     channel i data at bits [i*W +: W]
//   in_ready    per-channel grant (combinational)
//   out_valid   output word valid
//   out_ready   downstream ready
//   out_data    granted word
//   out_chan    channel index that supplied out_data
//   frame_cnt   completed ring revolutions, wraps
//   err_onehot  sticky: phase was not one-hot
//   err_seq     sticky: phase did not follow the rotation
//   clr_err     synchronous clear of both sticky errors
// -----------------------------------------------------------------------------
module tdm_slot_arbiter #(
  parameter int N = 4,
  parameter int W = 8,
  parameter int F = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N-1:0]         phase,
  input  logic [N-1:0]         in_valid,
  input  logic [N*W-1:0]       in_data,
  output logic [N-1:0]         in_ready,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [W-1:0]         out_data,
  output logic [$clog2(N)-1:0] out_chan,
  output logic [F-1:0]         frame_cnt,
  output logic                 err_onehot,
  output logic                 err_seq,
  input  logic                 clr_err
);

  localparam int CW = $clog2(N);

  logic          phase_ok;
  logic          space;
  logic          xfer;
  logic          seq_bad;
  logic          wrap;
  logic [N-1:0]  prev_phase;
  logic [N-1:0]  expected;
  logic          prev_vld;
  logic [CW-1:0] sel;

  // Exactly one bit set: non-zero and clearing the lowest set bit leaves zero.
  assign phase_ok = (phase != '0) && ((phase & (phase - N'(1))) == '0);

  // The output register can take a word if it is empty or draining now.
  assign space    = ~out_valid | out_ready;
  assign in_ready = (phase_ok && space) ? phase : '0;

  // in_ready is one-hot or zero, so at most one channel can transfer.
  assign xfer     = |(in_valid & in_ready);

  // NOTE: sel gets a default before the loop so no latch is inferred.
  always_comb begin
    sel = '0;
    for (int i = 0; i < N; i++) begin
      if (phase[i]) sel = CW'(i);
    end
  end

  assign expected = {prev_phase[N-2:0], prev_phase[N-1]};
  assign seq_bad  = prev_vld && (phase != expected);
  // A revolution completes when the top slot hands back to slot 0.
  assign wrap     = prev_vld && prev_phase[N-1] && phase[0] && phase_ok;

  // NOTE: all state updates use non-blocking assignments so every register
  // samples the values from before the edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid  <= 1'b0;
      out_data   <= '0;
      out_chan   <= '0;
      frame_cnt  <= '0;
      err_onehot <= 1'b0;
      err_seq    <= 1'b0;
      prev_phase <= '0;
      prev_vld   <= 1'b0;
    end else begin
      // A new word overwrites a word being popped in the same cycle.
      if (xfer) begin
        out_valid <= 1'b1;
        out_data  <= in_data[sel*W +: W];
        out_chan  <= sel;
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end

      prev_phase <= phase;
      prev_vld   <= 1'b1;

      if (wrap) frame_cnt <= frame_cnt + F'(1);

      // Setting an error takes priority over clearing it.
      if (!phase_ok)    err_onehot <= 1'b1;
      else if (clr_err) err_onehot <= 1'b0;

      if (seq_bad)      err_seq <= 1'b1;
      else if (clr_err) err_seq <= 1'b0;
    end
  end

endmodule

// File: tb/tb_tdm_slot_arbiter.sv
// -----------------------------------------------------------------------------
// tb_tdm_slot_arbiter
//
// Drives the phase vector like a ring counter (with deliberate faults) and
// checks the arbiter against a slot-level behavioural model every cycle,
// plus directed literal expectations. A second instance with F=2 shares all
// inputs to exercise frame counter wrap.
// -----------------------------------------------------------------------------
module tb_tdm_slot_arbiter;

  localparam int N  = 4;
  localparam int W  = 8;
  localparam int F  = 8;
  localparam int CW = 2;

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   phase;
  logic [N-1:0]   in_valid;
  logic [N*W-1:0] in_data;
  logic           out_ready;
  logic           clr_err;

  logic [N-1:0]   in_ready;
  logic           out_valid;
  logic [W-1:0]   out_data;
  logic [CW-1:0]  out_chan;
  logic [F-1:0]   frame_cnt;
  logic           err_onehot;
  logic           err_seq;

  logic [N-1:0]   in_ready2;
  logic           out_valid2;
  logic [W-1:0]   out_data2;
  logic [CW-1:0]  out_chan2;
  logic [1:0]     frame_cnt2;
  logic           err_onehot2;
  logic           err_seq2;

  int cmp_cnt = 0;
  int err_cnt = 0;
  bit chk_en  = 1'b0;

  always #5 clk = ~clk;

  tdm_slot_arbiter #(.N(N), .W(W), .F(F)) dut (
    .clk(clk), .rst(rst), .phase(phase), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_chan(out_chan), .frame_cnt(frame_cnt),
    .err_onehot(err_onehot), .err_seq(err_seq), .clr_err(clr_err)
  );

  tdm_slot_arbiter #(.N(N), .W(W), .F(2)) dut2 (
    .clk(clk), .rst(rst), .phase(phase), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready2), .out_valid(out_valid2), .out_ready(out_ready),
    .out_data(out_data2), .out_chan(out_chan2), .frame_cnt(frame_cnt2),
    .err_onehot(err_onehot2), .err_seq(err_seq2), .clr_err(clr_err)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    cmp_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic         m_valid;
  logic [W-1:0] m_data;
  int           m_chan;
  int           m_frame;
  bit           m_eo;
  bit           m_es;
  logic [N-1:0] m_last;
  bit           m_have;

  // Slot the ring should show after p, by doubling with end-around carry.
  function automatic logic [N-1:0] next_slot(input logic [N-1:0] p);
    logic [2*N-1:0] t;
    t = {{N{1'b0}}, p} << 1;
    return t[N-1:0] | t[2*N-1:N];
  endfunction

  // Channel accepted this cycle, or -1: the single active slot owner, if it
  // requests and the output word is absent or leaving.
  function automatic int pick();
    if ($countones(phase) != 1) return -1;
    if (m_valid && !out_ready) return -1;
    for (int i = 0; i < N; i++)
      if (phase[i] && in_valid[i]) return i;
    return -1;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_valid <= 1'b0;
      m_data  <= '0;
      m_chan  <= 0;
      m_frame <= 0;
      m_eo    <= 1'b0;
      m_es    <= 1'b0;
      m_last  <= '0;
      m_have  <= 1'b0;
    end else begin
      if (pick() >= 0) begin
        m_valid <= 1'b1;
        m_data  <= in_data[pick()*W +: W];
        m_chan  <= pick();
      end else if (m_valid && out_ready) begin
        m_valid <= 1'b0;
      end
      if ($countones(phase) != 1) m_eo <= 1'b1;
      else if (clr_err)           m_eo <= 1'b0;
      if (m_have && phase != next_slot(m_last)) m_es <= 1'b1;
      else if (clr_err)                         m_es <= 1'b0;
      if (m_have && m_last[N-1] && phase == N'(1)) m_frame <= m_frame + 1;
      m_last <= phase;
      m_have <= 1'b1;
    end
  end

  // Every-cycle comparison, sampled on the falling edge.
  always @(negedge clk) begin
    if (chk_en && !rst) begin
      check("in_ready", in_ready,
            ($countones(phase) == 1 && (!m_valid || out_ready)) ? phase : '0);
      check("out_valid", out_valid, m_valid);
      check("out_data", out_data, m_data);
      check("out_chan", out_chan, m_chan);
      check("frame_cnt", frame_cnt, m_frame % 256);
      check("err_onehot", err_onehot, m_eo);
      check("err_seq", err_seq, m_es);
      check("out_valid_f2", out_valid2, m_valid);
      check("frame_cnt_f2", frame_cnt2, m_frame % 4);
    end
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [7:0] dtab [4];
    int         ftab [5];
    int         fr;
    dtab = '{8'h10, 8'h21, 8'h32, 8'h43};
    ftab = '{1, 2, 3, 0, 1};

    rst       = 1'b1;
    phase     = 4'b0001;
    in_valid  = '0;
    in_data   = '0;
    out_ready = 1'b1;
    clr_err   = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst    = 1'b0;
    chk_en = 1'b1;

    // Reset state
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_out_chan", out_chan, 0);
    check("rst_frame", frame_cnt, 0);
    check("rst_errs", {err_onehot, err_seq}, 0);

    // All channels valid, full throughput, 21 cycles
    in_valid = '1;
    in_data  = {8'h43, 8'h32, 8'h21, 8'h10};
    for (int k = 0; k <= 20; k++) begin
      step();
      check("s1_valid", out_valid, 1);
      check("s1_chan", out_chan, k % 4);
      check("s1_data", out_data, dtab[k % 4]);
      // Revolutions complete at the ends of cycles 4 and 8.
      if (k == 8) check("s1_frame2", frame_cnt, 2);
      if (k > 0 && k % 4 == 0) check("f2_seq", frame_cnt2, ftab[k/4 - 1]);
      phase = next_slot(phase);
    end

    // Only channel 2 valid, then backpressure
    in_valid = 4'b0100;
    in_data  = {8'h00, 8'hA5, 8'h00, 8'h00};
    step();                               // phase 0010: old word drains
    phase = next_slot(phase);
    step();                               // phase 0100: capture A5
    check("s2_cap", {out_valid, out_data, 6'(out_chan)}, {1'b1, 8'hA5, 6'd2});
    out_ready = 1'b0;
    phase = next_slot(phase);
    for (int j = 0; j < 3; j++) begin
      #1;
      check("s2_stall_rdy", in_ready, 4'b0000);
      step();
      check("s2_hold", {out_valid, out_data, 6'(out_chan)}, {1'b1, 8'hA5, 6'd2});
      phase = next_slot(phase);
    end
    in_data[23:16] = 8'h5B;
    out_ready = 1'b1;
    #1;
    check("s2_rdy_0100", in_ready, 4'b0100);
    step();                               // pop and capture together
    check("s2_replace", {out_valid, out_data, 6'(out_chan)}, {1'b1, 8'h5B, 6'd2});
    phase = next_slot(phase);
    in_valid = '0;
    step();
    check("s2_drained", out_valid, 0);

    // Not-one-hot phase
    in_valid = '1;
    in_data  = {8'h43, 8'h32, 8'h21, 8'h10};
    phase    = 4'b0011;
    #1;
    check("s3_rdy_gated", in_ready, 4'b0000);
    step();
    check("s3_errs", {err_onehot, err_seq}, 2'b11);
    check("s3_no_grant", out_valid, 0);
    phase = 4'b0001;
    step();
    phase   = 4'b0010;
    clr_err = 1'b1;
    step();
    clr_err = 1'b0;
    check("s3_cleared", {err_onehot, err_seq}, 2'b00);

    // Skipped slot 0001 -> 0100
    phase = 4'b0100;
    step();
    phase = 4'b1000;
    step();
    phase = 4'b0001;
    step();
    fr = m_frame;
    phase = 4'b0100;
    step();
    check("s4_errs", {err_onehot, err_seq}, 2'b01);
    check("s4_frame", frame_cnt, fr);
    phase   = 4'b1000;
    clr_err = 1'b1;
    step();
    clr_err = 1'b0;
    check("s4_cleared", {err_onehot, err_seq}, 2'b00);
    phase = 4'b0001;

    // Reset pulse while a word is held
    step();
    phase = next_slot(phase);
    check("s5_pre_valid", out_valid, 1);
    rst = 1'b1;
    #1;
    check("s5_async_valid", out_valid, 0);
    check("s5_async_frame", frame_cnt, 0);
    #2;
    rst   = 1'b0;
    phase = 4'b0001;
    step();
    check("s5_no_seq_err", err_seq, 0);
    check("s5_first_word", {out_valid, out_data, 6'(out_chan)}, {1'b1, 8'h10, 6'd0});
    for (int k = 0; k < 6; k++) begin
      phase = next_slot(phase);
      step();
    end

    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
    $finish;
  end

endmodule
